// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------+
// | regfile_pkg : shared defaults, address type and FSM states for        |
// |               the kv32 multi-read-port register file                  |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

    localparam int c_XLEN = 32;
    localparam int c_NREG = 32;
    localparam int c_AW   = $clog2(c_NREG);

    typedef logic [c_AW-1:0] reg_addr_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// +----------------------------------------------------------------------+
// | regfile_scoreboard : pending-write busy bits with set-over-clear      |
// |                      priority and NRD independent busy read muxes     |
// | Revision           : 1.0  initial release                             |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = c_NREG,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    busy
);

    logic [NREG-1:0] r_busy;

    // Set is issued after clear so a same-cycle reservation of the written
    // register leaves it busy; callers never pass address 0, so bit 0 stays low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (clr_en) r_busy[clr_addr] <= 1'b0;
            if (set_en) r_busy[set_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign busy[i] = r_busy[ra[i*AW +: AW]];
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// +----------------------------------------------------------------------+
// | regfile_mp : NRD-read / 1-write integer register file with post-reset |
// |              clear sequencer and pending-write scoreboard.            |
// |              Optional zero-cycle write bypass: REGFILE_BYPASS_EN      |
// | Revision   : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN = c_XLEN,
    parameter  int NREG = c_NREG,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                rsv,
    input  logic [AW-1:0]       rsv_addr,
    output logic                init_done
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_run;
    logic            w_wr_en;
    logic            w_rsv_en;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_wa;
    logic [XLEN-1:0] w_mem_wd;
    logic [NRD-1:0]  w_sb_busy;
    logic [XLEN-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == INIT) begin
            w_cnt_nxt = r_cnt + AW'(1);
            if (r_cnt == AW'(NREG - 1)) w_state_nxt = RUN;
        end
    end

    assign w_run     = (r_state == RUN);
    assign init_done = w_run;
    assign w_wr_en   = w_run && we  && (wa != '0);
    assign w_rsv_en  = w_run && rsv && (rsv_addr != '0);

    // Single RAM write port shared by the clear sequencer and writeback;
    // entry 0 is never written and never read.
    assign w_mem_we = !w_run || w_wr_en;
    assign w_mem_wa = w_run ? wa : r_cnt;
    assign w_mem_wd = w_run ? wd : '0;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_rsv_en),
        .set_addr (rsv_addr),
        .clr_en   (w_wr_en),
        .clr_addr (wa),
        .ra       (ra),
        .busy     (w_sb_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_valid;
        assign w_ra    = ra[i*AW +: AW];
        assign w_valid = w_run && (w_ra != '0);
`ifdef REGFILE_BYPASS_EN
        logic w_fwd;
        assign w_fwd = w_wr_en && (wa == w_ra);
        assign rd[i*XLEN +: XLEN] = !w_valid ? '0 : (w_fwd ? wd : r_mem[w_ra]);
        assign rd_busy[i]         = w_valid && !w_fwd && w_sb_busy[i];
`else
        assign rd[i*XLEN +: XLEN] = w_valid ? r_mem[w_ra] : '0;
        assign rd_busy[i]         = w_valid && w_sb_busy[i];
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// +----------------------------------------------------------------------+
// | tb_regfile_mp : directed and random checks of regfile_mp against an  |
// |                 array-based reference model                          |
// | Revision      : 1.0  initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic                clk      = 1'b0;
    logic                rst      = 1'b1;
    logic [NRD*AW-1:0]   ra       = '0;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                we       = 1'b0;
    logic [AW-1:0]       wa       = '0;
    logic [XLEN-1:0]     wd       = '0;
    logic                rsv      = 1'b0;
    logic [AW-1:0]       rsv_addr = '0;
    logic                init_done;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] m_mem  [NREG];
    bit              m_busy [NREG];

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .rsv       (rsv),
        .rsv_addr  (rsv_addr),
        .init_done (init_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Reset, optionally abort INIT after abort_after edges, then count edges to init_done.
    task automatic reset_init(input int abort_after);
        int n;
        @(negedge clk);
        rst = 1'b1; we = 1'b0; rsv = 1'b0; ra = {5'd6, 5'd5};
        #1;
        check("rst_done", init_done, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_rd", rd, 0);
        @(negedge clk);
        rst = 1'b0; we = 1'b1; wa = 5'd5; wd = '1; rsv = 1'b1; rsv_addr = 5'd6;
        if (abort_after > 0) begin
            repeat (abort_after) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        n = 0;
        while (!init_done && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (!init_done) begin
                check("init_rd", rd, 0);
                check("init_busy", rd_busy, 0);
            end
        end
        check("init_cycles", n, 31);
        @(negedge clk);
        we = 1'b0; rsv = 1'b0;
        model_clear();
    endtask

    // One RUN cycle: drive, compare both ports to the model, clock, update model.
    task automatic cyc(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic w, input logic [AW-1:0] wadr, input logic [XLEN-1:0] wdat,
                       input logic r, input logic [AW-1:0] radr);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        logic            eb;
        ra = {a1, a0}; we = w; wa = wadr; wd = wdat; rsv = r; rsv_addr = radr;
        #2;
        for (int p = 0; p < NRD; p++) begin
            a = (p == 0) ? a0 : a1;
            if (a == 0) begin
                ed = '0; eb = 1'b0;
            end else if (c_BYP && w && wadr == a) begin
                ed = wdat; eb = 1'b0;
            end else begin
                ed = m_mem[a]; eb = m_busy[a];
            end
            check($sformatf("%s_rd%0d_a%0d", tag, p, a), rd[p*XLEN +: XLEN], ed);
            check($sformatf("%s_busy%0d_a%0d", tag, p, a), rd_busy[p], eb);
        end
        @(posedge clk);
        if (w && wadr != 0) begin
            m_mem[wadr]  = wdat;
            m_busy[wadr] = 1'b0;
        end
        if (r && radr != 0) m_busy[radr] = 1'b1;
        @(negedge clk);
    endtask

    task automatic peek(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0}; we = 1'b0; rsv = 1'b0;
        #2;
    endtask

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++) begin
            cyc("rnd",
                AW'($urandom_range(0, 11)), AW'($urandom_range(0, 31)),
                ($urandom % 2) == 0, AW'($urandom_range(0, 11)), $urandom,
                ($urandom % 3) == 0, AW'($urandom_range(0, 11)));
        end
    endtask

    initial begin
        model_clear();
        reset_init(0);

        for (int a = 1; a < NREG; a++)
            cyc("scan", AW'(a), AW'(NREG - a), 1'b0, '0, '0, 1'b0, '0);

        cyc("wr5", 5'd1, 5'd2, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0);
        peek(5'd5, 5'd5);
        check("x5_p0", rd[31:0], 32'hDEADBEEF);
        check("x5_p1", rd[63:32], 32'hDEADBEEF);

        cyc("x0", 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
        peek(5'd0, 5'd0);
        check("x0_rd", rd, 0);
        check("x0_busy", rd_busy, 0);

        cyc("rsv7", 5'd7, 5'd7, 1'b0, '0, '0, 1'b1, 5'd7);
        peek(5'd7, 5'd7);
        check("x7_busy_set", rd_busy, 2'b11);
        cyc("wr7", 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5, 1'b0, '0);
        peek(5'd7, 5'd1);
        check("x7_rd", rd[31:0], 32'hA5);
        check("x7_busy_clr", rd_busy[0], 0);

        cyc("rw9", 5'd0, 5'd0, 1'b1, 5'd9, 32'h0000_9999, 1'b1, 5'd9);
        peek(5'd9, 5'd9);
        check("x9_busy", rd_busy, 2'b11);
        check("x9_rd", rd[31:0], 32'h0000_9999);

        ra = {5'd3, 5'd0}; we = 1'b1; wa = 5'd3; wd = 32'h55; rsv = 1'b0;
        #1;
        check("byp3_rd", rd[63:32], c_BYP ? 32'h55 : 32'h0);
        check("byp3_busy", rd_busy[1], 0);
        cyc("byp3", 5'd0, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0, '0);

        random_run(400);

        reset_init(10);
        cyc("post", 5'd9, 5'd7, 1'b0, '0, '0, 1'b0, '0);
        cyc("post", 5'd5, 5'd3, 1'b0, '0, '0, 1'b0, '0);
        random_run(150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the kv32 core, successor to the fixed 2R1W 32×32 file. Adds a configurable number of read ports, a post-reset clear sequencer (distributed RAM cannot be reset), and a pending-write scoreboard for hazard detection. An optional write-to-read bypass is also available. Sits between decode (read addresses, reservations) and writeback (write port).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 4)
- NRD, 2, number of read ports
- AW, $clog2(NREG), register address width (derived; not overridden)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ra  in  NRD×AW  read addresses
- rd  out  NRD×XLEN  read data
- rd_busy  out  NRD  register at ra[i] has a pending write
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- rsv  in  1  reserve request: mark ra-independent register rsv_addr as pending
- rsv_addr  in  AW  register to reserve
- init_done  out  1  clear sequence complete; file usable

## Operation
- Register 0 is hardwired zero and is never stored. A read of address 0 returns 0, rd_busy is 0, and writes or reservations to 0 are ignored.
- FSM has two states, INIT and RUN.
  - rst asserts → INIT, clear counter = 1, all busy bits = 0, init_done = 0.
  - In INIT, each cycle writes 0 to entry[counter] and increments the counter. When counter = NREG−1 is written, the FSM moves to RUN and init_done = 1 from the next cycle.
  - In INIT, we and rsv are ignored, all rd = 0, and all rd_busy = 0.
  - rst asserted mid-INIT or in RUN restarts INIT from counter = 1. Stored contents become don't-care until they are re-cleared.
- Write, RUN only: if we and wa ≠ 0, entry[wa] ← wd at the rising edge, and busy[wa] clears.
- Reserve, RUN only: if rsv and rsv_addr ≠ 0, busy[rsv_addr] sets at the rising edge.
- Reserve and write to the same address in the same cycle: the reserve wins and busy stays 1 (a new producer is issued). The data write still occurs.
- Reserve of an already-busy register: the bit stays 1; there is no counting.
- Reads are combinational: rd[i] = entry[ra[i]] and rd_busy[i] = busy[ra[i]]. All read ports are independent, and any number of them may address the same register.

## Timing
- Reset values: init_done = 0, all rd = 0, all rd_busy = 0, all busy bits = 0.
- init_done rises exactly NREG−1 cycles after the first clock edge following rst deassertion (31 cycles for NREG = 32).
- Write-to-read latency:
  - Without bypass, data is visible on rd the cycle after the write edge.
  - With bypass, see Configuration.
- Reservation is visible on rd_busy the cycle after the rsv edge.
- Clear is visible on rd_busy the cycle after the write edge, unless bypassed.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if we and wa = ra[i] ≠ 0 in the same cycle, then rd[i] = wd and rd_busy[i] = 0 combinationally (zero-cycle forwarding).
- REGFILE_BYPASS_EN undefined: no forwarding. Same-cycle reads return the old value and the old busy state. The combinational path we/wa/wd → rd is removed.

## Structure
- Package regfile_pkg holds the XLEN default, the NREG default, the reg_addr_t typedef (AW bits), and the FSM state enum (INIT, RUN).
- Storage is a distributed-RAM array with one write port multiplexed between the clear sequencer and the external write.
- One sub-module, regfile_scoreboard: owns the NREG busy bits (flop array with async reset), the set/clear priority logic, and the NRD busy read muxes.

## Test plan
- Reset then idle, NREG = 32:
  - init_done rises on cycle 31.
  - Every ra in 1..31 reads 0 with rd_busy = 0.
- Write x5 = 0xDEADBEEF, read ra[0] = ra[1] = 5 next cycle → both 0xDEADBEEF.
- Write x0 = 0x12345678 and reserve x0 → reads of 0 return 0 with rd_busy = 0.
- Reserve x7 → rd_busy = 1 next cycle. Then write x7 = 0xA5 → rd_busy = 0 and rd = 0xA5 the cycle after.
- Reserve and write x9 in the same cycle → rd_busy = 1 afterwards and rd = written data.
- With REGFILE_BYPASS_EN, write x3 = 0x55 with ra[1] = 3 in the same cycle → rd[1] = 0x55 and rd_busy[1] = 0 that cycle.
- Assert rst at INIT cycle 10 → counter restarts and init_done rises 31 cycles after deassertion.
